// File: rtl/branch_resolve_unit.sv
// Resolves RISC-V conditional branches and JAL from ALU subtract flags, holds a
// redirect request until fetch acknowledges it, then drains with flushes asserted.
module branch_resolve_unit #(
    parameter int unsigned DRAIN_CYCLES = 1,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               BranchE,
    input  logic               JumpE,
    input  logic [2:0]         funct3E,
    input  logic               Zero,
    input  logic               Negative,
    input  logic               Carry,
    input  logic               OverFlow,
    input  logic [31:0]        PCE,
    input  logic [31:0]        ImmExtE,
    input  logic               RedirectAck,
    output logic               PCSrcM,
    output logic [31:0]        PCTargetM,
    output logic               FlushD,
    output logic               FlushE,
    output logic               BusyE,
    output logic               IllegalBr,
    output logic [COUNT_W-1:0] TakenCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REDIR = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_e             state_q;
    logic [3:0]         drain_q;
    logic               pcsrc_q;
    logic               flush_q;
    logic               illegal_q;
    logic [31:0]        target_q;
    logic [COUNT_W-1:0] count_q;

    logic cond;
    logic illegal_f3;
    logic take;

    // Branch condition decoded from the flags of A-B.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cond       = 1'b0;
        illegal_f3 = 1'b0;
        case (funct3E)
            3'b000: cond = Zero;
            3'b001: cond = ~Zero;
            3'b100: cond = Negative ^ OverFlow;
            3'b101: cond = ~(Negative ^ OverFlow);
            3'b110: cond = ~Carry;
            3'b111: cond = Carry;
            3'b010,
            3'b011: illegal_f3 = 1'b1;
        endcase
        take = JumpE | (BranchE & cond);
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            drain_q   <= 4'd0;
            pcsrc_q   <= 1'b0;
            flush_q   <= 1'b0;
            illegal_q <= 1'b0;
            target_q  <= 32'd0;
            count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (BranchE && illegal_f3) begin
                        illegal_q <= 1'b1;
                    end
                    if (take) begin
                        target_q <= PCE + ImmExtE;
                        pcsrc_q  <= 1'b1;
                        flush_q  <= 1'b1;
                        state_q  <= ST_REDIR;
                        if (count_q != '1) begin
                            count_q <= count_q + COUNT_W'(1);
                        end
                    end
                end
                ST_REDIR: begin
                    if (RedirectAck) begin
                        pcsrc_q <= 1'b0;
                        drain_q <= DRAIN_LOAD;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Flushes drop on the edge where the counter reads one.
                    if (drain_q == 4'd1) begin
                        flush_q <= 1'b0;
                        drain_q <= 4'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        drain_q <= drain_q - 4'd1;
                    end
                end
                default: begin
                    pcsrc_q <= 1'b0;
                    flush_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PCSrcM     = pcsrc_q;
    assign PCTargetM  = target_q;
    assign FlushD     = flush_q;
    assign FlushE     = flush_q;
    assign BusyE      = flush_q;
    assign IllegalBr  = illegal_q;
    assign TakenCount = count_q;

endmodule
